// File: rtl/async_step_batcher.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : async_step_batcher                                               |
// | Brief   : Per-channel step accumulation, round-robin batched transfers and |
// |           periodic host result polling. Optional macro                     |
// |           ASYNC_BATCH_DRAIN_EN flushes residual counts before halting.     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module async_step_batcher #(
    parameter int NUM_CH       = 4,
    parameter int STEP_WIDTH   = 8,
    parameter int ACC_WIDTH    = 16,
    parameter int FLUSH_THRESH = 64,
    parameter int FETCH_PERIOD = 5000,
    parameter int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_CH*STEP_WIDTH-1:0] step,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CH_W-1:0]              out_ch,
    output logic [ACC_WIDTH-1:0]         out_count,
    output logic                         poll_req,
    input  logic                         poll_ack,
    input  logic                         poll_result,
    output logic                         simv_result,
    output logic                         overflow,
    output logic                         busy
);

    localparam int                   c_timer_w  = $clog2(FETCH_PERIOD);
    localparam logic [c_timer_w-1:0] c_timer_last = c_timer_w'(FETCH_PERIOD - 1);
    localparam logic [ACC_WIDTH-1:0] c_acc_max  = '1;
    localparam logic [ACC_WIDTH-1:0] c_thresh   = ACC_WIDTH'(FLUSH_THRESH);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_POLL  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t               state_q,       state_d;
    logic [c_timer_w-1:0] timer_q,       timer_d;
    logic [CH_W-1:0]      rr_ptr_q,      rr_ptr_d;
    logic [ACC_WIDTH-1:0] acc_q [NUM_CH];
    logic [ACC_WIDTH-1:0] acc_d [NUM_CH];
    logic                 out_valid_q,   out_valid_d;
    logic [CH_W-1:0]      out_ch_q,      out_ch_d;
    logic [ACC_WIDTH-1:0] out_count_q,   out_count_d;
    logic                 poll_req_q,    poll_req_d;
    logic                 simv_result_q, simv_result_d;
    logic                 overflow_q,    overflow_d;

    logic                 w_accept;
    logic                 w_drain;
    logic                 w_hs;
    logic                 w_ack_done;
    logic                 w_can_sel;
    logic                 w_found;
    logic                 w_load;
    logic                 w_all_zero;
    logic [CH_W-1:0]      w_sel;
    logic [CH_W-1:0]      w_idx_ch;
    logic [NUM_CH-1:0]    w_elig;
    logic [ACC_WIDTH-1:0] w_step_ext;
    logic [ACC_WIDTH:0]   w_sum;
    int                   w_idx;

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        rr_ptr_d      = rr_ptr_q;
        out_valid_d   = out_valid_q;
        out_ch_d      = out_ch_q;
        out_count_d   = out_count_q;
        simv_result_d = simv_result_q;
        overflow_d    = overflow_q;
        w_found       = 1'b0;
        w_sel         = '0;
        w_idx         = 0;
        w_idx_ch      = '0;
        w_step_ext    = '0;
        w_sum         = '0;
        w_elig        = '0;
        w_all_zero    = 1'b1;

        w_accept   = (state_q == ST_RUN) || (state_q == ST_POLL);
        w_drain    = (state_q == ST_DRAIN);
        w_hs       = out_valid_q && out_ready;
        w_ack_done = (state_q == ST_POLL) && poll_ack && poll_result;

        for (int c = 0; c < NUM_CH; c++) begin
            if (acc_q[c] != '0) begin
                w_all_zero = 1'b0;
            end
            if (w_accept) begin
                w_elig[c] = (acc_q[c] >= c_thresh);
            end else if (w_drain) begin
                w_elig[c] = (acc_q[c] != '0);
            end
        end

        // Without drain, the terminating ack must not launch a fresh transfer.
`ifdef ASYNC_BATCH_DRAIN_EN
        w_can_sel = !out_valid_q || w_hs;
`else
        w_can_sel = (!out_valid_q || w_hs) && !w_ack_done;
`endif

        for (int k = 0; k < NUM_CH; k++) begin
            w_idx = int'(rr_ptr_q) + k;
            if (w_idx >= NUM_CH) begin
                w_idx = w_idx - NUM_CH;
            end
            w_idx_ch = CH_W'(w_idx);
            if (!w_found && w_elig[w_idx_ch]) begin
                w_found = 1'b1;
                w_sel   = w_idx_ch;
            end
        end
        w_load = w_can_sel && w_found;

        for (int c = 0; c < NUM_CH; c++) begin
            acc_d[c]   = acc_q[c];
            w_step_ext = {{(ACC_WIDTH-STEP_WIDTH){1'b0}}, step[c*STEP_WIDTH +: STEP_WIDTH]};
            w_sum      = {1'b0, acc_q[c]} + {1'b0, w_step_ext};
            if (w_load && (w_sel == CH_W'(c))) begin
                acc_d[c] = w_accept ? w_step_ext : '0;
            end else if (w_accept) begin
                if (w_sum[ACC_WIDTH]) begin
                    acc_d[c]   = c_acc_max;
                    overflow_d = 1'b1;
                end else begin
                    acc_d[c] = w_sum[ACC_WIDTH-1:0];
                end
            end
        end

        if (w_hs) begin
            out_valid_d = 1'b0;
        end
        if (w_load) begin
            out_valid_d = 1'b1;
            out_ch_d    = w_sel;
            out_count_d = acc_q[w_sel];
            rr_ptr_d    = (int'(w_sel) == NUM_CH - 1) ? '0 : w_sel + 1'b1;
        end

        case (state_q)
            ST_RUN: begin
                if (timer_q == c_timer_last) begin
                    timer_d = '0;
                    state_d = ST_POLL;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_POLL: begin
                if (poll_ack) begin
                    if (poll_result) begin
                        simv_result_d = 1'b1;
`ifdef ASYNC_BATCH_DRAIN_EN
                        state_d = ST_DRAIN;
`else
                        state_d = ST_DONE;
                        for (int c = 0; c < NUM_CH; c++) begin
                            acc_d[c] = '0;
                        end
`endif
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_all_zero && (!out_valid_q || w_hs)) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_DONE;
            end
        endcase

        poll_req_d = (state_d == ST_POLL);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= ST_RUN;
            timer_q       <= '0;
            rr_ptr_q      <= '0;
            out_valid_q   <= 1'b0;
            out_ch_q      <= '0;
            out_count_q   <= '0;
            poll_req_q    <= 1'b0;
            simv_result_q <= 1'b0;
            overflow_q    <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                acc_q[c] <= '0;
            end
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            rr_ptr_q      <= rr_ptr_d;
            out_valid_q   <= out_valid_d;
            out_ch_q      <= out_ch_d;
            out_count_q   <= out_count_d;
            poll_req_q    <= poll_req_d;
            simv_result_q <= simv_result_d;
            overflow_q    <= overflow_d;
            for (int c = 0; c < NUM_CH; c++) begin
                acc_q[c] <= acc_d[c];
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_ch      = out_ch_q;
    assign out_count   = out_count_q;
    assign poll_req    = poll_req_q;
    assign simv_result = simv_result_q;
    assign overflow    = overflow_q;
    assign busy        = out_valid_q || !w_all_zero;

endmodule
`default_nettype wire

// File: tb/tb_async_step_batcher.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_async_step_batcher                                            |
// | Brief   : Directed self-checking bench for async_step_batcher.             |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_async_step_batcher;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default parameters
    logic        a_rst_n, a_out_valid, a_out_ready, a_poll_req, a_poll_ack, a_poll_result;
    logic        a_simv, a_ovf, a_busy;
    logic [31:0] a_step;
    logic [1:0]  a_out_ch;
    logic [15:0] a_out_count;

    // Instance B: narrow accumulator, short poll period
    logic        b_rst_n, b_out_valid, b_out_ready, b_poll_req, b_poll_ack, b_poll_result;
    logic        b_simv, b_ovf, b_busy;
    logic [31:0] b_step;
    logic [1:0]  b_out_ch;
    logic [8:0]  b_out_count;

    async_step_batcher u_dut_a (
        .clock(clk), .reset(a_rst_n), .step(a_step),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ch(a_out_ch),
        .out_count(a_out_count), .poll_req(a_poll_req), .poll_ack(a_poll_ack),
        .poll_result(a_poll_result), .simv_result(a_simv), .overflow(a_ovf),
        .busy(a_busy)
    );

    async_step_batcher #(.ACC_WIDTH(9), .FETCH_PERIOD(20)) u_dut_b (
        .clock(clk), .reset(b_rst_n), .step(b_step),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ch(b_out_ch),
        .out_count(b_out_count), .poll_req(b_poll_req), .poll_ack(b_poll_ack),
        .poll_result(b_poll_result), .simv_result(b_simv), .overflow(b_ovf),
        .busy(b_busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    int exp_ch  [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int exp_cnt [8] = '{100, 200, 300, 400, 400, 400, 400, 400};
    int xf_ch   [4];
    int xf_cnt  [4];
    int n_xf;
    int cyc;

    initial begin
        a_rst_n = 0; a_step = '0; a_out_ready = 0; a_poll_ack = 0; a_poll_result = 0;
        b_rst_n = 0; b_step = '0; b_out_ready = 0; b_poll_ack = 0; b_poll_result = 0;
        ticks(3);

        check("rst_valid", a_out_valid, 0);
        check("rst_ch",    a_out_ch,    0);
        check("rst_count", a_out_count, 0);
        check("rst_poll",  a_poll_req,  0);
        check("rst_simv",  a_simv,      0);
        check("rst_ovf",   a_ovf,       0);
        check("rst_busy",  a_busy,      0);

        // ch1 steps by 8: threshold reached at edge 8, transfer visible after edge 9
        a_step = 32'h0000_0800; a_out_ready = 1; a_rst_n = 1;
        ticks(8);
        check("t1_pre_valid", a_out_valid, 0);
        check("t1_pre_busy",  a_busy,      1);
        tick();
        check("t1_valid", a_out_valid, 1);
        check("t1_ch",    a_out_ch,    1);
        check("t1_count", a_out_count, 64);
        tick();
        check("t1_gap_valid", a_out_valid, 0);
        ticks(7);
        check("t1_2nd_valid", a_out_valid, 1);
        check("t1_2nd_count", a_out_count, 64);

        // Reset while a transfer is pending aborts it
        a_rst_n = 0;
        tick();
        check("abort_valid", a_out_valid, 0);

        // Backpressure for 10 cycles
        a_out_ready = 0; a_rst_n = 1;
        ticks(9);
        check("hold_start_valid", a_out_valid, 1);
        check("hold_start_count", a_out_count, 64);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_valid", a_out_valid, 1);
            check("hold_ch",    a_out_ch,    1);
            check("hold_count", a_out_count, 64);
        end
        a_out_ready = 1;
        tick();
        check("hold_next_valid", a_out_valid, 1);
        check("hold_next_count", a_out_count, 88);

        // Steps of 100 on every channel: round robin with growing counts
        a_rst_n = 0;
        tick();
        a_step = 32'h6464_6464; a_rst_n = 1;
        ticks(2);
        for (int i = 0; i < 8; i++) begin
            check("rr_valid", a_out_valid, 1);
            check("rr_ch",    a_out_ch,    exp_ch[i]);
            check("rr_count", a_out_count, exp_cnt[i]);
            tick();
        end
        check("rr_ovf", a_ovf, 0);
        a_rst_n = 0; a_step = '0;

        // Saturation on a 9-bit accumulator
        b_step = 32'h0000_00FF; b_out_ready = 0; b_rst_n = 1;
        ticks(2);
        check("sat_first_valid", b_out_valid, 1);
        check("sat_first_count", b_out_count, 255);
        tick();
        check("sat_pre_ovf", b_ovf, 0);
        tick();
        check("sat_ovf",        b_ovf,       1);
        check("sat_hold_count", b_out_count, 255);
        b_out_ready = 1;
        tick();
        check("sat_count", b_out_count, 511);
        b_step = '0; b_rst_n = 0;
        tick();
        check("sat_rst_ovf", b_ovf, 0);

        // Polling and termination with residuals 5,0,3,0
        b_step = 32'h0003_0005; b_rst_n = 1;
        tick();
        cyc = 1;
        b_step = '0;
        check("poll_pre_busy", b_busy,     1);
        check("poll_pre_req",  b_poll_req, 0);
        while (!b_poll_req && cyc < 60) begin
            tick();
            cyc++;
        end
        check("poll1_cycle", cyc, 20);
        b_poll_ack = 1; b_poll_result = 0;
        tick();
        cyc++;
        b_poll_ack = 0;
        check("poll1_req_drop", b_poll_req, 0);
        check("poll1_simv",     b_simv,     0);
        while (!b_poll_req && cyc < 80) begin
            tick();
            cyc++;
        end
        check("poll2_cycle", cyc, 41);
        b_poll_ack = 1; b_poll_result = 1;
        tick();
        b_poll_ack = 0; b_poll_result = 0;
        check("ack_simv", b_simv, 1);
`ifdef ASYNC_BATCH_DRAIN_EN
        check("ack_busy", b_busy, 1);
`else
        check("ack_busy", b_busy, 0);
`endif
        n_xf = 0;
        for (int i = 0; i < 4; i++) begin
            xf_ch[i]  = 9;
            xf_cnt[i] = 999;
        end
        for (int i = 0; i < 8; i++) begin
            if (b_out_valid && n_xf < 4) begin
                xf_ch[n_xf]  = int'(b_out_ch);
                xf_cnt[n_xf] = int'(b_out_count);
                n_xf++;
            end
            tick();
        end
`ifdef ASYNC_BATCH_DRAIN_EN
        check("drain_n",    n_xf,      2);
        check("drain0_ch",  xf_ch[0],  0);
        check("drain0_cnt", xf_cnt[0], 5);
        check("drain1_ch",  xf_ch[1],  2);
        check("drain1_cnt", xf_cnt[1], 3);
`else
        check("done_n", n_xf, 0);
`endif
        check("done_busy",  b_busy,      0);
        check("done_valid", b_out_valid, 0);
        check("done_req",   b_poll_req,  0);
        check("done_simv",  b_simv,      1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
